// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 encodings and
// small size helpers shared with the decoder.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3[1:0] carries the access size for both loads and stores
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/halfword lane of the bus
// word and sign- or zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [15:0] lane;

  always_comb begin
    case (off_i)
      2'd0:    lane = word_i[15:0];
      2'd1:    lane = word_i[23:8];
      2'd2:    lane = word_i[31:16];
      default: lane = {8'h00, word_i[31:24]};
    endcase
  end

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_LH:   data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
      F3_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one req/gnt + rvalid data-bus transaction per WB-stage
// access, steers store lanes, extends load data, traps misalignment and timeouts.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [3:0]      dbus_be,
  input  logic            dbus_gnt,
  input  logic            dbus_rvalid,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            loaded,
  output logic [XLEN-1:0] rdata,
  output logic            busy,
  output logic            misaligned,
  output logic            bus_err
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d, mis_q, mis_d, err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [XLEN-1:0] ld_data;
  logic            access, bad, start, tmo_hit;

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .word_i   (dbus_rdata),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  assign access  = mem_read | mem_write;
  assign bad     = is_misaligned(funct3, addr[1:0]);
  assign start   = (state_q == IDLE) & access & ~bad;
  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_q == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    be_d    = be_q;
    we_d    = we_q;
    tmo_d   = tmo_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && bad) begin
          mis_d = 1'b1;
        end else if (access) begin
          addr_d  = addr;
          f3_d    = funct3;
          we_d    = mem_write;
          be_d    = lane_be(funct3, addr[1:0]);
          tmo_d   = TMO_LOAD;
          state_d = REQ;
          case (funct3[1:0])
            2'b00:   wdata_d = {4{wdata[7:0]}};
            2'b01:   wdata_d = {2{wdata[15:0]}};
            default: wdata_d = wdata;
          endcase
        end
      end
      REQ: begin
        // rvalid without gnt is stale and must not be captured
        if (dbus_gnt) begin
          if (we_q) begin
            state_d = DONE;
          end else if (dbus_rvalid) begin
            rdata_d = ld_data;
            state_d = DONE;
          end else begin
            tmo_d   = TMO_LOAD;
            state_d = RESP;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      RESP: begin
        if (dbus_rvalid) begin
          rdata_d = ld_data;
          state_d = DONE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      tmo_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      be_q    <= be_d;
      we_q    <= we_d;
      tmo_q   <= tmo_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign dbus_req   = (state_q == REQ);
  assign dbus_we    = dbus_req & we_q;
  assign dbus_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dbus_wdata = wdata_q;
  assign dbus_be    = be_q;
  assign loaded     = (state_q == DONE) & ~we_q;
  assign rdata      = rdata_q;
  // DONE releases the pipeline in the same cycle loaded is seen
  assign busy       = (state_q == REQ) | (state_q == RESP) | start;
  assign misaligned = mis_q;
  assign bus_err    = err_q;

endmodule
